// File: rtl/cpu_decode_stage.sv
// Registered instruction-decode stage: handshake in, one-deep decoded bundle out.
// Optional macro DECODE_PERF_CNT_EN adds stall_cycles / illegal_count counters.
module cpu_decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 6,
    parameter int IMM_SEXT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [XLEN-1:0]       pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] src_reg1,
    output logic [REG_ADDR_W-1:0] src_reg2,
    output logic [REG_ADDR_W-1:0] dst_reg,
    output logic [XLEN-1:0]       immediate_value,
    output logic                  immediate,
    output logic                  jump,
    output logic                  branch,
    output logic                  write_reg,
    output logic                  write_mem,
    output logic                  read_mem,
    output logic                  illegal,
    output logic [XLEN-1:0]       jump_address,
    output logic [3:0]            aluop
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           illegal_count
`endif
);

    localparam logic [3:0] ALUOP_ADD = 4'h0;
    localparam logic [3:0] ALUOP_AND = 4'h1;
    localparam logic [3:0] ALUOP_NEQ = 4'h2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;

    typedef enum logic {
        RUN,
        LOAD_WAIT
    } state_t;

    state_t state;
    logic [REG_ADDR_W-1:0] load_dst;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_zx;
    logic [XLEN-1:0] imm_ext;

    logic is_nop;
    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_bne;
    logic is_j;

    logic [REG_ADDR_W-1:0] d_src1;
    logic [REG_ADDR_W-1:0] d_src2;
    logic [REG_ADDR_W-1:0] d_dst;
    logic d_imm;
    logic d_jump;
    logic d_branch;
    logic d_wr;
    logic d_wm;
    logic d_rm;
    logic d_ill;
    logic [XLEN-1:0] d_ja;
    logic [3:0] d_aluop;

    logic stall;
    logic accept;

    // Shift amount field is not used by any supported instruction.
    logic unused_shamt;
    assign unused_shamt = ^instruction[10:6];

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rs     = REG_ADDR_W'(instruction[25:21]);
    assign rt     = REG_ADDR_W'(instruction[20:16]);
    assign rd     = REG_ADDR_W'(instruction[15:11]);

    assign imm_sx  = XLEN'(signed'(instruction[15:0]));
    assign imm_zx  = XLEN'(instruction[15:0]);
    assign imm_ext = (IMM_SEXT != 0) ? imm_sx : imm_zx;

    assign is_nop  = (instruction == 32'h0);
    assign is_r    = (opcode == OP_RTYPE) && !is_nop;
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_bne  = (opcode == OP_BNE);
    assign is_j    = (opcode == OP_J);

    // Combinational decode of the presented instruction into a bundle.
    always_comb begin
        d_src1   = '0;
        d_src2   = '0;
        d_dst    = '0;
        d_imm    = 1'b0;
        d_jump   = 1'b0;
        d_branch = 1'b0;
        d_wr     = 1'b0;
        d_wm     = 1'b0;
        d_rm     = 1'b0;
        d_ill    = 1'b0;
        d_ja     = '0;
        d_aluop  = ALUOP_ADD;
        unique case (1'b1)
            is_nop: begin
            end
            is_r: begin
                if (funct == FN_ADD || funct == FN_AND) begin
                    d_src1  = rs;
                    d_src2  = rt;
                    d_dst   = rd;
                    d_wr    = 1'b1;
                    d_aluop = (funct == FN_AND) ? ALUOP_AND : ALUOP_ADD;
                end else begin
                    d_ill = 1'b1;
                end
            end
            is_addi: begin
                d_src1 = rs;
                d_dst  = rt;
                d_imm  = 1'b1;
                d_wr   = 1'b1;
            end
            is_lw: begin
                d_src1 = rs;
                d_dst  = rt;
                d_imm  = 1'b1;
                d_rm   = 1'b1;
                d_wr   = 1'b1;
            end
            is_sw: begin
                d_src1 = rs;
                d_src2 = rt;
                d_imm  = 1'b1;
                d_wm   = 1'b1;
            end
            is_bne: begin
                d_src1   = rs;
                d_src2   = rt;
                d_branch = 1'b1;
                d_aluop  = ALUOP_NEQ;
                d_ja     = pc + XLEN'(4) + (imm_sx << 2);
            end
            is_j: begin
                d_jump = 1'b1;
                d_ja   = XLEN'({instruction[25:0], 2'b00});
            end
            default: begin
                d_ill = 1'b1;
            end
        endcase
        if (d_dst == '0) begin
            d_wr = 1'b0;
        end
    end

    assign stall = (state == LOAD_WAIT) && in_valid && (load_dst != '0) &&
                   ((d_src1 == load_dst) || (d_src2 == load_dst));

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    // Output bundle register: load on accept, hold on backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            src_reg1        <= '0;
            src_reg2        <= '0;
            dst_reg         <= '0;
            immediate_value <= '0;
            immediate       <= 1'b0;
            jump            <= 1'b0;
            branch          <= 1'b0;
            write_reg       <= 1'b0;
            write_mem       <= 1'b0;
            read_mem        <= 1'b0;
            illegal         <= 1'b0;
            jump_address    <= '0;
            aluop           <= ALUOP_ADD;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            src_reg1        <= d_src1;
            src_reg2        <= d_src2;
            dst_reg         <= d_dst;
            immediate_value <= imm_ext;
            immediate       <= d_imm;
            jump            <= d_jump;
            branch          <= d_branch;
            write_reg       <= d_wr;
            write_mem       <= d_wm;
            read_mem        <= d_rm;
            illegal         <= d_ill;
            jump_address    <= d_ja;
            aluop           <= d_aluop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Load-use FSM: one wait cycle after every load with a live destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            load_dst <= '0;
        end else if (flush) begin
            state <= RUN;
        end else if (out_valid && out_ready && read_mem && dst_reg != '0) begin
            state    <= LOAD_WAIT;
            load_dst <= dst_reg;
        end else begin
            state <= RUN;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Saturating counters for stall cycles and accepted illegal instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            illegal_count <= '0;
        end else begin
            if (stall && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (accept && d_ill && illegal_count != 32'hFFFF_FFFF) begin
                illegal_count <= illegal_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed bench for cpu_decode_stage with a queue scoreboard of expected bundles.
// Expected bundles are written out by hand per instruction.
module tb_cpu_decode_stage;

    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] AND = 4'h1;
    localparam logic [3:0] NEQ = 4'h2;

    typedef struct packed {
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic [5:0]  d;
        logic [31:0] imm;
        logic [6:0]  fl;
        logic [31:0] ja;
        logic [3:0]  op;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  src_reg1;
    logic [5:0]  src_reg2;
    logic [5:0]  dst_reg;
    logic [31:0] immediate_value;
    logic        immediate;
    logic        jump;
    logic        branch;
    logic        write_reg;
    logic        write_mem;
    logic        read_mem;
    logic        illegal;
    logic [31:0] jump_address;
    logic [3:0]  aluop;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] illegal_count;
`endif

    int tests = 0;
    int fails = 0;
    bundle_t sb[$];
    bundle_t got;

    always #5 clk = ~clk;

    cpu_decode_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instruction(instruction),
        .pc(pc),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .src_reg1(src_reg1),
        .src_reg2(src_reg2),
        .dst_reg(dst_reg),
        .immediate_value(immediate_value),
        .immediate(immediate),
        .jump(jump),
        .branch(branch),
        .write_reg(write_reg),
        .write_mem(write_mem),
        .read_mem(read_mem),
        .illegal(illegal),
        .jump_address(jump_address),
        .aluop(aluop)
`ifdef DECODE_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .illegal_count(illegal_count)
`endif
    );

    assign got = {src_reg1, src_reg2, dst_reg, immediate_value,
                  {immediate, jump, branch, write_reg, write_mem, read_mem, illegal},
                  jump_address, aluop};

    // flags order: immediate, jump, branch, write_reg, write_mem, read_mem, illegal
    function automatic bundle_t mk(input logic [5:0] s1, input logic [5:0] s2,
                                   input logic [5:0] d, input logic [31:0] imm,
                                   input logic [6:0] fl, input logic [31:0] ja,
                                   input logic [3:0] op);
        bundle_t b;
        b = {s1, s2, d, imm, fl, ja, op};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted; expected bundle goes to the scoreboard.
    task automatic send(input logic [31:0] ins, input logic [31:0] p,
                        input bundle_t e, output int waited);
        in_valid    = 1'b1;
        instruction = ins;
        pc          = p;
        waited      = 0;
        #1;
        while (!in_ready && waited < 8) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (in_ready) sb.push_back(e);
        chk("accept", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare every handed-off bundle with the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out observed=%h expected=none", got);
            end
            if (sb.size() != 0) begin
                bundle_t e;
                e = sb.pop_front();
                tests++;
                assert (got === e) else begin
                    fails++;
                    $error("FAIL bundle observed=%h expected=%h", got, e);
                end
            end
        end
    end

    initial begin
        bundle_t b_add3;
        bundle_t b_snap;
        int w;
        b_add3 = mk(6'd1, 6'd2, 6'd3, 32'h1820, 7'b0001000, 32'h0, ADD);

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        pc          = 32'h0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        repeat (2) tick();
        chk("reset_bundle", 128'(got), 128'd0);
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        rst_n = 1'b1;
        tick();

        send(32'h00221820, 32'h0, b_add3, w);
        chk("add_valid", {127'd0, out_valid}, 128'd1);
        tick();
        chk("valid_drop", {127'd0, out_valid}, 128'd0);

        send(32'h1422FFFF, 32'h100,
             mk(6'd1, 6'd2, 6'd0, 32'hFFFFFFFF, 7'b0010000, 32'h100, NEQ), w);
        send(32'h20200005, 32'h104,
             mk(6'd1, 6'd0, 6'd0, 32'h5, 7'b1000000, 32'h0, ADD), w);
        send(32'h00223824, 32'h108,
             mk(6'd1, 6'd2, 6'd7, 32'h3824, 7'b0001000, 32'h0, AND), w);
        send(32'h08000040, 32'h10C,
             mk(6'd0, 6'd0, 6'd0, 32'h40, 7'b0100000, 32'h100, ADD), w);
        send(32'hAC220008, 32'h110,
             mk(6'd1, 6'd2, 6'd0, 32'h8, 7'b1000100, 32'h0, ADD), w);
        send(32'h2041FFFD, 32'h114,
             mk(6'd2, 6'd0, 6'd1, 32'hFFFFFFFD, 7'b1001000, 32'h0, ADD), w);
        send(32'h00000000, 32'h118, mk(6'd0, 6'd0, 6'd0, 32'h0, 7'b0, 32'h0, ADD), w);
        tick();

        send(32'h8C240000, 32'h200,
             mk(6'd1, 6'd0, 6'd4, 32'h0, 7'b1001010, 32'h0, ADD), w);
        tick();
        send(32'h00822820, 32'h204,
             mk(6'd4, 6'd2, 6'd5, 32'h2820, 7'b0001000, 32'h0, ADD), w);
        chk("load_use_stall", 128'(w), 128'd1);
        tick();

        send(32'h8C240000, 32'h300,
             mk(6'd1, 6'd0, 6'd4, 32'h0, 7'b1001010, 32'h0, ADD), w);
        tick();
        send(32'h00C22820, 32'h304,
             mk(6'd6, 6'd2, 6'd5, 32'h2820, 7'b0001000, 32'h0, ADD), w);
        chk("no_stall", 128'(w), 128'd0);
        tick();

        out_ready = 1'b0;
        send(32'h00221820, 32'h400, b_add3, w);
        b_snap      = got;
        in_valid    = 1'b1;
        instruction = 32'h00223824;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", {127'd0, in_ready}, 128'd0);
            chk("hold_valid", {127'd0, out_valid}, 128'd1);
            chk("hold_bundle", 128'(got), 128'(b_snap));
            tick();
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", {127'd0, in_ready}, 128'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        out_ready = 1'b1;
        tick();

        send(32'hFC000000, 32'h500,
             mk(6'd0, 6'd0, 6'd0, 32'h0, 7'b0000001, 32'h0, ADD), w);
        send(32'h00000001, 32'h504,
             mk(6'd0, 6'd0, 6'd0, 32'h1, 7'b0000001, 32'h0, ADD), w);
`ifdef DECODE_PERF_CNT_EN
        chk("illegal_count", 128'(illegal_count), 128'd2);
        chk("stall_cycles", 128'(stall_cycles), 128'd1);
`endif
        tick();

        out_ready = 1'b0;
        send(32'h00221820, 32'h600, b_add3, w);
        rst_n = 1'b0;
        tick();
        chk("midreset_bundle", 128'(got), 128'd0);
        chk("midreset_valid", {127'd0, out_valid}, 128'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("midreset_cnt", 128'(illegal_count), 128'd0);
`endif
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(32'h00822820, 32'h700,
             mk(6'd4, 6'd2, 6'd5, 32'h2820, 7'b0001000, 32'h0, ADD), w);
        chk("post_reset_run", 128'(w), 128'd0);

        repeat (3) tick();
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
